instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of instruction addresses and pointer.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, width of one instruction word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE/HALTED and begin fetching.
REQ-006 SHALL have port halt_req  input  1  stop issuing new fetches.
REQ-007 SHALL have port ptr_in  input  ADDR_WIDTH  current instruction pointer value.
REQ-008 SHALL have port ptr_enable  output  1  advance pointer by 1 at this edge.
REQ-009 SHALL have port ptr_load_en  output  1  load pointer with ptr_load_val.
REQ-010 SHALL have port ptr_load_val  output  ADDR_WIDTH  pointer load value.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  instruction memory read address.
REQ-012 SHALL have port mem_rd_en  output  1  memory read strobe; data returns next cycle.
REQ-013 SHALL have port mem_data  input  INSTR_WIDTH  read data, valid the cycle after mem_rd_en.
REQ-014 SHALL have port jump_en  input  1  redirect request from decoder.
REQ-015 SHALL have port jump_addr  input  ADDR_WIDTH  redirect target.
REQ-016 SHALL have port instr_out  output  INSTR_WIDTH  head instruction.
REQ-017 SHALL have port instr_addr  output  ADDR_WIDTH  address of head instruction.
REQ-018 SHALL have port instr_valid  output  1  head entry valid.
REQ-019 SHALL have port instr_ready  input  1  consumer accepts head when instr_valid high.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HALTED; IDLE->RUN on start; RUN->HALTED on halt_req; HALTED->RUN on start; halt_req has priority over start when both are high.
REQ-021 SHALL hold a 2-entry FIFO of {instruction, address} pairs plus a 1-bit in-flight flag.
REQ-022 SHALL issue a fetch (mem_rd_en=1, ptr_enable=1, mem_addr=ptr_in) in a cycle iff state is RUN, jump_en=0, halt_req=0, and count + inflight - pop < 2, where pop = instr_valid & instr_ready.
REQ-023 SHALL drive ptr_enable and mem_rd_en combinationally and identically; mem_addr SHALL equal ptr_in at all times.
REQ-024 SHALL capture the address of each issued fetch and push {mem_data, captured address} into the FIFO in the following cycle, unless flushed.
REQ-025 SHALL present the FIFO head registered: an instruction issued in cycle t is visible on instr_out/instr_valid in cycle t+2.
REQ-026 SHALL sustain one instruction per cycle when instr_ready is held high.
REQ-027 SHALL, on jump_en=1 in any state: assert ptr_load_en=1 with ptr_load_val=jump_addr combinationally that cycle, suppress issue that cycle, and at the edge clear all FIFO entries and the in-flight flag.
REQ-028 SHALL honour a pop (instr_valid & instr_ready) in the jump cycle as a completed handshake; all other entries are discarded.
REQ-029 SHALL drive instr_valid=0 in the cycle after a jump and first issue from the new pointer in that cycle.
REQ-030 SHALL allow simultaneous push and pop on a full FIFO with count unchanged; a push into a full FIFO without a pop SHALL be impossible by REQ-022.
REQ-031 SHALL in HALTED still accept the in-flight return and let the consumer drain the FIFO.
REQ-032 SHALL drive ptr_load_en=0 and ptr_load_val=0 whenever jump_en=0.

Reset
REQ-033 SHALL on reset enter IDLE, empty the FIFO, clear in-flight, drive instr_valid=0, instr_out=0, instr_addr=0.
REQ-034 SHALL on reset asserted mid-operation discard any returning mem_data and issue nothing during the reset cycle.
REQ-035 SHALL take reset priority over start, halt_req and jump_en.

Verification
REQ-036 SHALL cover: ptr_in=0, start pulse, instr_ready=1, mem holds addr*3 -> instr_valid from 2 cycles after first issue, addresses 0,1,2,... one per cycle.
REQ-037 SHALL cover: instr_ready=0 after start -> exactly 2 fetches issued (addr 0,1), ptr_enable then held low; instr_ready=1 -> head addr 0 then 1, issue resumes.
REQ-038 SHALL cover: jump_en with jump_addr=0x40 while FIFO full and one in flight -> ptr_load_en=1, ptr_load_val=0x40 that cycle, instr_valid=0 next cycle, next delivered addr 0x40.
REQ-039 SHALL cover: halt_req during streaming -> no mem_rd_en after that cycle, remaining entries drain, start -> fetch resumes from current ptr_in.
REQ-040 SHALL cover: reset asserted one cycle after an issue -> instr_valid=0, FIFO empty, state IDLE, returning mem_data never appears on instr_out.
REQ-041 SHALL cover: jump_en in the same cycle as a pop of addr 5 -> addr 5 counted delivered once, no entry with addr 6 delivered.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. Issues reads against a single-cycle-latency
//   instruction memory, buffers up to two {instruction, address} pairs and
//   presents the oldest one to a valid/ready consumer. A decoder redirect
//   (jump_en) reloads the external pointer and flushes everything buffered.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   start, halt_req  : run control (halt_req wins over start)
//   ptr_in           : current external instruction pointer
//   ptr_enable       : pointer increment strobe (same as mem_rd_en)
//   ptr_load_en/_val : pointer reload on redirect
//   mem_addr, mem_rd_en, mem_data : instruction memory read port
//   jump_en, jump_addr            : redirect request
//   instr_out, instr_addr, instr_valid, instr_ready : head of FIFO handshake
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [ADDR_WIDTH-1:0]  ptr_in,
  output logic                   ptr_enable,
  output logic                   ptr_load_en,
  output logic [ADDR_WIDTH-1:0]  ptr_load_val,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd_en,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   jump_en,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t                 r_state;
  logic [INSTR_WIDTH-1:0] r_fifo_instr [2];
  logic [ADDR_WIDTH-1:0]  r_fifo_addr  [2];
  logic [1:0]             r_count;
  logic                   r_inflight_p1;
  logic [ADDR_WIDTH-1:0]  r_inflight_addr_p1;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [2:0] w_occ;

  // Slot 0 is always the head, so the outputs come straight from registers.
  assign instr_valid = (r_count != 2'd0);
  assign instr_out   = r_fifo_instr[0];
  assign instr_addr  = r_fifo_addr[0];

  assign w_pop  = instr_valid & instr_ready;
  // Occupancy after this cycle's pop, counting the read already in flight.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight_p1} - {2'b00, w_pop};
  assign w_issue = ~reset & (r_state == S_RUN) & ~jump_en & ~halt_req
                 & (w_occ < 3'd2);
  assign w_push = r_inflight_p1 & ~jump_en;

  assign mem_addr     = ptr_in;
  assign mem_rd_en    = w_issue;
  assign ptr_enable   = w_issue;
  assign ptr_load_en  = jump_en & ~reset;
  assign ptr_load_val = ptr_load_en ? jump_addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_count            <= 2'd0;
      r_inflight_p1      <= 1'b0;
      r_inflight_addr_p1 <= '0;
      r_fifo_instr[0]    <= '0;
      r_fifo_instr[1]    <= '0;
      r_fifo_addr[0]     <= '0;
      r_fifo_addr[1]     <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (!halt_req && start) r_state <= S_RUN;
        S_RUN:    if (halt_req)           r_state <= S_HALTED;
        S_HALTED: if (!halt_req && start) r_state <= S_RUN;
        default:                          r_state <= S_IDLE;
      endcase

      // ---- issue stage -> return stage ----
      if (jump_en) begin
        // A pop in this cycle is a completed handshake; everything else goes.
        r_count       <= 2'd0;
        r_inflight_p1 <= 1'b0;
      end else begin
        r_inflight_p1 <= w_issue;
        if (w_issue) r_inflight_addr_p1 <= ptr_in;

        // ---- return stage -> FIFO ----
        if (w_push && !w_pop) begin
          if (r_count[0]) begin
            r_fifo_instr[1] <= mem_data;
            r_fifo_addr[1]  <= r_inflight_addr_p1;
          end else begin
            r_fifo_instr[0] <= mem_data;
            r_fifo_addr[0]  <= r_inflight_addr_p1;
          end
          r_count <= r_count + 2'd1;
        end else if (!w_push && w_pop) begin
          r_fifo_instr[0] <= r_fifo_instr[1];
          r_fifo_addr[0]  <= r_fifo_addr[1];
          r_count         <= r_count - 2'd1;
        end else if (w_push && w_pop) begin
          // Count unchanged; new entry lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_fifo_instr[0] <= mem_data;
            r_fifo_addr[0]  <= r_inflight_addr_p1;
          end else begin
            r_fifo_instr[0] <= r_fifo_instr[1];
            r_fifo_addr[0]  <= r_fifo_addr[1];
            r_fifo_instr[1] <= mem_data;
            r_fifo_addr[1]  <= r_inflight_addr_p1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Bench for instr_fetch: a pointer register and a one-cycle-latency memory
//   holding addr*3 model the environment; a per-cycle vector table covers
//   back-pressure, redirect and halt; a scoreboard queue checks the delivered
//   stream across a jump-with-pop; a short sequence covers mid-run reset.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset, start, halt_req, jump_en, instr_ready;
  logic [AW-1:0] ptr_in, ptr_load_val, mem_addr, jump_addr, instr_addr;
  logic          ptr_enable, ptr_load_en, mem_rd_en, instr_valid;
  logic [IW-1:0] mem_data, instr_out;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .ptr_in(ptr_in), .ptr_enable(ptr_enable), .ptr_load_en(ptr_load_en),
    .ptr_load_val(ptr_load_val), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_data(mem_data), .jump_en(jump_en), .jump_addr(jump_addr),
    .instr_out(instr_out), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  // Environment: external pointer register and instruction memory.
  logic [AW-1:0] ptr;
  assign ptr_in = ptr;
  always @(posedge clk) begin
    if (reset)            ptr <= '0;
    else if (ptr_load_en) ptr <= ptr_load_val;
    else if (ptr_enable)  ptr <= ptr + 1'b1;
    if (mem_rd_en) mem_data <= {{(IW-AW){1'b0}}, mem_addr} * 32'd3;
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  bit            sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, look at outputs 1 ns later.
  task automatic step(input logic rs, input logic s, input logic h, input logic r,
                      input logic j, input logic [AW-1:0] ja);
    logic [AW-1:0] e;
    @(negedge clk);
    reset = rs; start = s; halt_req = h; instr_ready = r; jump_en = j; jump_addr = ja;
    #1;
    if (sb_en && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got addr %0h expected no delivery", instr_addr);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", 32'(instr_addr), 32'(e));
        check("sb_data", instr_out, 32'(e) * 32'd3);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_out",   instr_out, 0);
    check("rst_addr",  32'(instr_addr), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic s, h, r, j; logic [AW-1:0] ja;
    logic rd; logic [AW-1:0] ma; logic v; logic [AW-1:0] ia; logic ld;
  } vec_t;
  vec_t tbl[19];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; jump_en = 1'b0;
    instr_ready = 1'b0; jump_addr = '0;

    //            s  h  r  j  ja     rd ma     v  ia     ld
    tbl[0]  = '{1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0};
    tbl[1]  = '{0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0};
    tbl[2]  = '{0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0};
    tbl[3]  = '{0, 0, 0, 0, 8'h00, 0, 8'h02, 1, 8'h00, 0};
    tbl[4]  = '{0, 0, 0, 0, 8'h00, 0, 8'h02, 1, 8'h00, 0};
    tbl[5]  = '{0, 0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 0};
    tbl[6]  = '{0, 0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01, 0};
    tbl[7]  = '{0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 8'h02, 0};
    tbl[8]  = '{0, 0, 0, 1, 8'h40, 0, 8'h04, 1, 8'h02, 1};
    tbl[9]  = '{0, 0, 0, 0, 8'h00, 1, 8'h40, 0, 8'h00, 0};
    tbl[10] = '{0, 0, 0, 0, 8'h00, 1, 8'h41, 0, 8'h00, 0};
    tbl[11] = '{0, 0, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40, 0};
    tbl[12] = '{0, 1, 1, 0, 8'h00, 0, 8'h43, 1, 8'h41, 0};
    tbl[13] = '{0, 0, 1, 0, 8'h00, 0, 8'h43, 1, 8'h42, 0};
    tbl[14] = '{0, 0, 1, 0, 8'h00, 0, 8'h43, 0, 8'h00, 0};
    tbl[15] = '{1, 0, 1, 0, 8'h00, 0, 8'h43, 0, 8'h00, 0};
    tbl[16] = '{0, 0, 1, 0, 8'h00, 1, 8'h43, 0, 8'h00, 0};
    tbl[17] = '{0, 0, 1, 0, 8'h00, 1, 8'h44, 0, 8'h00, 0};
    tbl[18] = '{0, 0, 1, 0, 8'h00, 1, 8'h45, 1, 8'h43, 0};

    // Back-pressure, redirect on a full FIFO, halt/drain/restart.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(1'b0, tbl[i].s, tbl[i].h, tbl[i].r, tbl[i].j, tbl[i].ja);
      check($sformatf("v%0d_rd_en", i),   32'(mem_rd_en),   32'(tbl[i].rd));
      check($sformatf("v%0d_ptr_en", i),  32'(ptr_enable),  32'(tbl[i].rd));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr),   32'(tbl[i].ma));
      check($sformatf("v%0d_valid", i),   32'(instr_valid), 32'(tbl[i].v));
      check($sformatf("v%0d_ld_en", i),   32'(ptr_load_en), 32'(tbl[i].ld));
      check($sformatf("v%0d_ld_val", i),  32'(ptr_load_val),
            tbl[i].j ? 32'(tbl[i].ja) : 32'd0);
      if (tbl[i].v) begin
        check($sformatf("v%0d_iaddr", i), 32'(instr_addr), 32'(tbl[i].ia));
        check($sformatf("v%0d_idata", i), instr_out, 32'(tbl[i].ia) * 32'd3);
      end
    end

    // Streaming at one per cycle, jump coinciding with the pop of addr 5.
    do_reset();
    for (int a = 0; a < 6; a++) exp_q.push_back(AW'(a));
    for (int a = 0; a < 6; a++) exp_q.push_back(AW'(8'h20 + a));
    sb_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int c = 1; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20);
    check("jmp_ld_en", 32'(ptr_load_en), 1);
    check("jmp_q_left", exp_q.size(), 6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("jmp_next_valid", 32'(instr_valid), 0);
    check("jmp_next_addr", 32'(mem_addr), 32'h20);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    sb_en = 1'b0;
    check("sb_drained", exp_q.size(), 0);

    // Reset one cycle after an issue; stale return must never surface.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("mr_issue", 32'(mem_rd_en), 1);
    check("mr_issue_addr", 32'(mem_addr), 32'h10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("mr_rst_no_issue", 32'(mem_rd_en), 0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check($sformatf("mr_valid%0d", c), 32'(instr_valid), 0);
      check($sformatf("mr_out%0d", c),   instr_out, 0);
      check($sformatf("mr_idle%0d", c),  32'(mem_rd_en), 0);
    end
    // halt_req beats start in IDLE; start alone then runs.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("prio_stay_idle", 32'(mem_rd_en), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("prio_run", 32'(mem_rd_en), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
